// File: rtl/serial_pkg.sv
// Shared definitions for the one-bit-per-clock serial link (receiver and serializer side).
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_rx_shifter.sv
// Data shift register and bit counter for the serial receiver.
// Bits enter at the MSB so the first received bit ends up in bit 0.
module serial_rx_shifter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              shift_en_i,
    input  logic              bit_i,
    output logic [DATA_W-1:0] word_o,
    output logic              done_o
);

    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;

    assign word_o = shreg_q;
    assign done_o = shift_en_i && (cnt_q == CNT_W'(DATA_W - 1));

    // Counter wraps to zero on the last data bit, so it is ready for the next frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en_i) begin
            shreg_q <= {bit_i, shreg_q[DATA_W-1:1]};
            cnt_q   <= done_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W bits LSB-first, optional even parity, stop bit.
// Define SERIAL_RX_PARITY_EN to insert the parity bit between the data and stop bits.
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              si,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    rx_state_t         state_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              err_q;
    logic              busy_q;
    logic [DATA_W-1:0] word;
    logic              word_done;
    logic              parity_ok;

    serial_rx_shifter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .clock      (clock),
        .reset      (reset),
        .shift_en_i (state_q == DATA),
        .bit_i      (si),
        .word_o     (word),
        .done_o     (word_done)
    );

`ifdef SERIAL_RX_PARITY_EN
    logic par_bad_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_bad_q <= 1'b0;
        end else if (state_q == PARITY) begin
            par_bad_q <= ^{si, word};
        end
    end

    assign parity_ok = !par_bad_q;
`else
    assign parity_ok = 1'b1;
`endif

    // Pulses default low every cycle; only the STOP state raises one of them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (si == START_BIT) begin
                        state_q <= DATA;
                        busy_q  <= 1'b1;
                    end
                end
                DATA: begin
                    if (word_done) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    state_q <= STOP;
                end
`endif
                STOP: begin
                    if (si == STOP_BIT && parity_ok) begin
                        data_q  <= word;
                        valid_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;

endmodule
